// File: rtl/packet_tx.sv
// Packet transmitter: latches one packet per handshake and streams it as
// head/body/tail flits, with a sequence number in the head and an XOR checksum in the tail.
//
//   state  | meaning
//   S_IDLE | waiting for a packet, pkt_ready high
//   S_HEAD | presenting the head flit
//   S_BODY | presenting body word idx
//   S_TAIL | presenting the checksum flit
module packet_tx #(
    parameter int FLIT_WIDTH = 64,
    parameter int MAX_BODY   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    input  logic [7:0]                     pkt_dst_id,
    input  logic [7:0]                     pkt_src_id,
    input  logic [7:0]                     pkt_body_len,
    input  logic [MAX_BODY*FLIT_WIDTH-1:0] pkt_body,
    output logic                           flit_valid,
    input  logic                           flit_ready,
    output logic [FLIT_WIDTH-1:0]          flit_data,
    output logic [1:0]                     flit_type,
    output logic                           busy
);

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

    localparam int         IDX_W   = (MAX_BODY > 1) ? $clog2(MAX_BODY) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BODY);

    state_t                  state_q, state_d;
    logic [7:0]              dst_q, dst_d, src_q, src_d, len_q, len_d, seq_q, seq_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [FLIT_WIDTH-1:0]   csum_q, csum_d;
    logic [FLIT_WIDTH-1:0]   body_q [MAX_BODY];
    logic [FLIT_WIDTH-1:0]   body_d [MAX_BODY];
    logic                    flit_valid_q, flit_valid_d;
    logic [FLIT_WIDTH-1:0]   flit_data_q, flit_data_d;
    logic [1:0]              flit_type_q, flit_type_d;
    logic                    busy_q, busy_d;
    logic                    pkt_ready_q, pkt_ready_d;

    logic                    accept;
    logic                    fire;
    logic                    last_body;
    logic [7:0]              eff_len;

    assign accept    = (state_q == S_IDLE) && pkt_valid && pkt_ready_q;
    assign fire      = flit_valid_q && flit_ready;
    assign last_body = ((8'(idx_q) + 8'd1) == len_q);
    assign eff_len   = (pkt_body_len > MAX_LEN) ? MAX_LEN : pkt_body_len;

    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        src_d   = src_q;
        len_d   = len_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        body_d  = body_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dst_d  = pkt_dst_id;
                    src_d  = pkt_src_id;
                    len_d  = eff_len;
                    idx_d  = '0;
                    csum_d = '0;
                    for (int i = 0; i < MAX_BODY; i++) begin
                        body_d[i] = pkt_body[i*FLIT_WIDTH +: FLIT_WIDTH];
                    end
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                if (fire) begin
                    csum_d  = csum_q ^ flit_data_q;
                    state_d = (len_q != 8'd0) ? S_BODY : S_TAIL;
                end
            end
            S_BODY: begin
                if (fire) begin
                    csum_d = csum_q ^ flit_data_q;
                    if (last_body) begin
                        state_d = S_TAIL;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (fire) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are built from the next-state values so every port comes straight off a flop.
        flit_valid_d = (state_d != S_IDLE);
        busy_d       = (state_d != S_IDLE);
        pkt_ready_d  = (state_d == S_IDLE);
        flit_type_d  = 2'b00;
        flit_data_d  = '0;
        case (state_d)
            S_HEAD: flit_data_d[FLIT_WIDTH-1 -: 32] = {dst_d, src_d, len_d, seq_d};
            S_BODY: begin
                flit_type_d = 2'b01;
                flit_data_d = body_d[idx_d];
            end
            S_TAIL: begin
                flit_type_d = 2'b10;
                flit_data_d = csum_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            seq_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            len_q        <= '0;
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
            flit_type_q  <= 2'b00;
            busy_q       <= 1'b0;
            pkt_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            len_q        <= len_d;
            flit_valid_q <= flit_valid_d;
            flit_data_q  <= flit_data_d;
            flit_type_q  <= flit_type_d;
            busy_q       <= busy_d;
            pkt_ready_q  <= pkt_ready_d;
        end
    end

    // Body words are pure data; they are only consumed after a fresh accept.
    always_ff @(posedge clk) begin
        body_q <= body_d;
    end

    assign flit_valid = flit_valid_q;
    assign flit_data  = flit_data_q;
    assign flit_type  = flit_type_q;
    assign busy       = busy_q;
    assign pkt_ready  = pkt_ready_q;

endmodule

// File: doc/packet_tx.md
# packet_tx

Packet transmitter for the collision-avoidance interconnect. It accepts one whole packet per handshake: destination, source, body length and up to MAX_BODY body words. It serialises the packet into a head/body/tail flit stream with a valid/ready handshake, adds a per-packet sequence number, and appends an XOR checksum in the tail flit. It sits between a node's packet generator and the router input port, and is the send side of the flit receiver.

## Interface
- FLIT_WIDTH, 64, bits per flit; must be ≥ 32.
- MAX_BODY, 4, maximum body flits per packet; must be ≥ 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- pkt_valid  in  1  packet offered.
- pkt_ready  out  1  transmitter can accept a packet.
- pkt_dst_id  in  8  destination node id.
- pkt_src_id  in  8  source node id.
- pkt_body_len  in  8  number of body flits, 0..MAX_BODY.
- pkt_body  in  MAX_BODY*FLIT_WIDTH  body words; word i at bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- flit_valid  out  1  flit_data/flit_type valid.
- flit_ready  in  1  downstream accepts the flit.
- flit_data  out  FLIT_WIDTH  flit payload.
- flit_type  out  2  flit type: 2'b00 head, 2'b01 body, 2'b10 tail.
- busy  out  1  a packet is latched and not yet fully sent.

## Operation
- **FSM states:** IDLE, HEAD, BODY, TAIL.
- **IDLE:**
  - pkt_ready=1, flit_valid=0.
  - On pkt_valid&&pkt_ready: latch all pkt_* inputs and go to HEAD.
  - The effective length is min(pkt_body_len, MAX_BODY); lengths above MAX_BODY are clamped, not rejected.
- **HEAD:**
  - flit_type=00.
  - flit_data = {dst[7:0], src[7:0], eff_len[7:0], seq[7:0]} in the top 32 bits; lower bits are zero.
  - On flit_ready: go to BODY if eff_len>0, else TAIL.
- **BODY:**
  - flit_type=01, flit_data = latched body word idx, with idx starting at 0.
  - On flit_ready: idx+1. After word eff_len-1, go to TAIL.
- **TAIL:**
  - flit_type=10, flit_data = XOR of the head flit_data and every body flit_data sent for this packet.
  - On flit_ready: go to IDLE and increment seq.
- **Sequence number:**
  - seq is an 8-bit counter, reset value 0, incremented once per completed packet (tail handshake).
  - Wraps 255→0.
- **Output stability:** while flit_valid=1 and flit_ready=0, flit_data and flit_type stay stable. The transmitter never drops flit_valid before the handshake.
- **Input decoupling:** pkt_* inputs are ignored outside IDLE. The latched copy is used, so the upstream side may change its inputs immediately after the accept.
- **busy:** busy = (state != IDLE); pkt_ready = (state == IDLE).
- **Reset:**
  - State returns to IDLE; seq, idx and the checksum accumulator go to 0.
  - Reset values: flit_valid=0, flit_data=0, flit_type=00, busy=0, pkt_ready=0 during the reset cycle, then pkt_ready=1 from the first cycle after rst deasserts.
- **Reset mid-packet:** the packet is abandoned with no tail emitted, and the partially sent flits are not retried. A reset asserted together with a handshake overrides the handshake.

## Timing
- **Accept to head:** packet accepted at edge t; head flit valid during cycle t+1. All outputs are registered.
- **Throughput:** with flit_ready held 1, one flit per cycle. A packet is eff_len+2 flits, occupying cycles t+1..t+eff_len+2.
- **Back-to-back packets:** pkt_ready returns the cycle after the tail handshake, so the next packet's head appears at the earliest 2 cycles after the previous tail (1-cycle bubble).
- **Combinational paths:** no combinational path from flit_ready to flit_valid/flit_data, nor from pkt_valid to pkt_ready.
- **Checksum accumulator:** cleared on accept, XORed with each flit on its handshake edge. The tail value is therefore ready in the cycle following the last body handshake.

## Test plan
- **Reset values:** assert rst for 2 cycles → flit_valid=0, busy=0, pkt_ready=0 while rst is high; pkt_ready=1 the cycle after release.
- **Single packet, flit_ready=1:**
  - Stimulus: dst=0x12, src=0x34, len=2, body0=0xAAAA…, body1=0x5555….
  - Head top 32 bits = 0x12340200. Then body0, body1. Then tail = head^body0^body1.
  - flit_type sequence 00,01,01,10 on consecutive cycles.
- **Zero-length packet:** len=0 → exactly head then tail, and tail data == head data.
- **Backpressure:**
  - Toggle flit_ready 1,0,0,1,… during the 3-body packet → each flit is held stable while ready=0.
  - No flit is skipped or duplicated; the checksum is still correct.
- **Sequence and clamping:**
  - Send 257 packets → seq fields read 0..255 then 0.
  - A packet with len=9 sends exactly MAX_BODY=4 body flits and reports 4 in its header.
- **Reset mid-packet:** assert rst after the first body handshake of a len=3 packet → no tail is emitted, flit_valid=0 the next cycle, and the next packet's header carries seq=0.
